// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: owns HI/LO, computes the result at the
// Start edge into a pending register and commits it after a fixed busy period.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        ph_q, ph_d;
  logic [31:0]        pl_q, pl_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               is_signed;
  logic [63:0]        mul_a, mul_b, product;
  logic               a_neg, b_neg, b_zero;
  logic [31:0]        a_mag, b_mag, den, q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = ~MDop[0];
    mul_a     = {(is_signed & SrcA[31]) ? '1 : 32'h0, SrcA};
    mul_b     = {(is_signed & SrcB[31]) ? '1 : 32'h0, SrcB};
    product   = mul_a * mul_b;

    // Signed divide done on magnitudes so INT_MIN / -1 wraps to 0x80000000 cleanly
    a_neg  = is_signed & SrcA[31];
    b_neg  = is_signed & SrcB[31];
    a_mag  = a_neg ? (~SrcA + 32'd1) : SrcA;
    b_mag  = b_neg ? (~SrcB + 32'd1) : SrcB;
    b_zero = (SrcB == '0);
    den    = b_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / den;
    r_mag  = a_mag % den;
    quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          unique case (MDop)
            3'd0, 3'd1: begin
              ph_d    = product[63:32];
              pl_d    = product[31:0];
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = S_MULT;
              busy_d  = 1'b1;
            end
            3'd2, 3'd3: begin
              ph_d    = rem;
              pl_d    = quot;
              dz_d    = b_zero;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = S_DIV;
              busy_d  = 1'b1;
            end
            3'd4:    hi_d = SrcA;
            3'd5:    lo_d = SrcA;
            default: ;
          endcase
        end
      end
      S_MULT, S_DIV: begin
        if (cnt_q == '0) begin
          if (!dz_q) begin
            hi_d = ph_q;
            lo_d = pl_q;
          end
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy  = busy_q;
  assign Stall = busy_q | (Start & ~MDop[2]);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table of single operations plus
// hand-written sequences for reset, ignored Start and consecutive mthi/mtlo.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDop;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Stall;
  logic [31:0] HI, LO;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDop  (MDop),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Busy  (Busy),
    .Stall (Stall),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, scrambles operands while busy, counts busy cycles, checks HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int unsigned ecyc);
    int unsigned n;
    Start = 1'b1;
    MDop  = op;
    SrcA  = a;
    SrcB  = b;
    #1;
    check({name, " stall"}, {31'd0, Stall}, {31'd0, (op <= 3'd3)});
    tick();
    Start = 1'b0;
    SrcA  = $urandom();
    SrcB  = $urandom();
    n = 0;
    while (Busy && n < 100) begin
      n++;
      tick();
    end
    check({name, " busy_cycles"}, n, ecyc);
    check({name, " HI"}, HI, ehi);
    check({name, " LO"}, LO, elo);
  endtask

  initial begin
    int unsigned n;

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[4]  = '{3'd4, 32'h55555555, 32'h0,        32'h55555555, 32'd14,       0};
    vecs[5]  = '{3'd5, 32'h55555555, 32'h0,        32'h55555555, 32'h55555555, 0};
    vecs[6]  = '{3'd2, 32'd5,        32'h0,        32'h55555555, 32'h55555555, 10};
    vecs[7]  = '{3'd3, 32'd7,        32'h0,        32'h55555555, 32'h55555555, 10};
    vecs[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[9]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[10] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[11] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[12] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[13] = '{3'd6, 32'h12345678, 32'h9ABCDEF0, 32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[14] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

    reset = 1'b1;
    Start = 1'b1;
    MDop  = 3'd0;
    SrcA  = 32'd3;
    SrcB  = 32'd4;
    tick();
    tick();
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    Start = 1'b0;
    #1;
    check("reset stall", {31'd0, Stall}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc);

    // Consecutive mthi / mtlo
    Start = 1'b1; MDop = 3'd4; SrcA = 32'h12345678;
    tick();
    check("mthi HI", HI, 32'h12345678);
    check("mthi busy", {31'd0, Busy}, 32'd0);
    MDop = 3'd5; SrcA = 32'h9ABCDEF0;
    tick();
    Start = 1'b0;
    check("mtlo LO", LO, 32'h9ABCDEF0);
    check("mtlo HI", HI, 32'h12345678);
    check("mtlo busy", {31'd0, Busy}, 32'd0);

    // Start of a mult during busy cycle 3 of a div must be ignored
    Start = 1'b1; MDop = 3'd2; SrcA = 32'd1000; SrcB = 32'd9;
    tick();
    Start = 1'b0;
    n = 1;
    tick();
    n++;
    Start = 1'b1; MDop = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
    #1;
    check("ignored stall", {31'd0, Stall}, 32'd1);
    tick();
    n++;
    Start = 1'b0; SrcA = 32'hDEADBEEF; SrcB = 32'h0;
    check("midop HI", HI, 32'h12345678);
    check("midop LO", LO, 32'h9ABCDEF0);
    while (Busy && n < 100) begin
      n++;
      tick();
    end
    check("ignored busy_cycles", n - 1, 32'd10);
    check("ignored HI", HI, 32'd1);
    check("ignored LO", LO, 32'd111);
    repeat (6) tick();
    check("no mult busy", {31'd0, Busy}, 32'd0);
    check("no mult HI", HI, 32'd1);
    check("no mult LO", LO, 32'd111);

    // Reset during busy cycle 2 of a mult
    Start = 1'b1; MDop = 3'd0; SrcA = 32'd6; SrcB = 32'd7;
    tick();
    Start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", {31'd0, Busy}, 32'd0);
    check("midreset HI", HI, 32'd0);
    check("midreset LO", LO, 32'd0);
    run_op("post reset mult", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the MIPS datapath, sitting beside the ALU in the EX stage. It accepts mult/multu/div/divu/mthi/mtlo operations, holds the architectural HI/LO registers, and sequences each multiply or divide over a fixed number of busy cycles. It exports Busy/Stall so the hazard unit can freeze dependent instructions (mfhi/mflo, further MD ops) until the result is committed.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  operation valid this cycle (one-cycle pulse per instruction)
- MDop  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
- SrcA  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
- SrcB  input  32  rt operand (divisor / multiplier)
- Busy  output  1  registered; high while a mult/div is in flight
- Stall  output  1  combinational, Busy | (Start & MDop ≤ 3)
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

## Operation
- States: IDLE, MULT, DIV. Down-counter cnt (width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES))+1).
- IDLE + Start + MDop 0/1: latch 64-bit product (signed for 0, unsigned for 1) into internal pending {ph,pl}; cnt ← MULT_CYCLES-1; → MULT.
- IDLE + Start + MDop 2/3: latch quotient→pl, remainder→ph (signed for 2, unsigned for 3); cnt ← DIV_CYCLES-1; → DIV.
- IDLE + Start + MDop 4: HI ← SrcA next edge; 5: LO ← SrcA next edge; stay IDLE, Busy stays 0.
- MDop 6/7 with Start: no effect.
- MULT/DIV: cnt decrements each cycle; on cycle with cnt==0, next edge: HI ← ph, LO ← pl, → IDLE.
- Start while Busy: ignored entirely (hazard unit must hold it via Stall); HI/LO and in-flight op unaffected.
- Signed div: quotient truncates toward zero; remainder takes sign of dividend (−7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF).
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Divide by zero (either signedness): operation still runs DIV_CYCLES busy cycles; on completion HI and LO keep their previous values.
- Operands are sampled only at the Start edge; SrcA/SrcB changes during Busy have no effect.

## Timing
- Reset (synchronous, active-high): state=IDLE, cnt=0, Busy=0, HI=0, LO=0, pending discarded; overrides Start in the same cycle.
- Reset mid-operation: in-flight result dropped, HI/LO = 0 next cycle, Busy = 0 next cycle.
- Start sampled at edge E0 for mult: Busy=1 in cycles after E0 … through E0+MULT_CYCLES; HI/LO new values and Busy=0 visible after edge E0+MULT_CYCLES. Same for div with DIV_CYCLES.
- Back-to-back: a Start in the first cycle with Busy=0 after completion is accepted (zero dead cycles).
- mthi/mtlo: value visible on HI/LO one cycle after the Start edge; Busy never asserts.
- Stall asserts combinationally in the Start cycle of a mult/div so the following MD-dependent instruction is held immediately.
- HI/LO change only at completion edge, at mthi/mtlo edge, or on reset; never mid-operation.

## Test plan
- Reset then mult SrcA=0xFFFFFFFF, SrcB=0x00000002 (MDop 0) -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div SrcA=0xFFFFFFF9 (−7), SrcB=2 (MDop 2) -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> HI/LO updated one cycle after each, Busy stays 0.
- Start mult while div in flight (cycle 3 of 10), with operand changes -> second Start ignored, div result committed at cycle 10, no mult result ever appears.
- HI=LO=0x55555555 via mthi/mtlo, then div by 0 -> Busy 10 cycles, HI/LO remain 0x55555555; then 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mult started, reset asserted in busy cycle 2 -> next cycle Busy=0, HI=LO=0, subsequent mult accepted and completes normally.
